// File: rtl/datapath_result_checker.sv
// Read-back checker for the datapath ALU self-test: walks register-file port A
// over R0..R(NUM_REGS-1), compares against a fixed table and reports mismatches.
module datapath_result_checker #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rd_data,
  output logic [3:0]       rd_addr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count,
  output logic [3:0]       first_fail_addr,
  output logic [WIDTH-1:0] first_fail_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [4:0]       err_q, err_d;
  logic [3:0]       ffa_q, ffa_d;
  logic [WIDTH-1:0] ffd_q, ffd_d;
  logic             mismatch;

  // Values the stimulus sequencer is expected to have left in each register.
  function automatic logic [WIDTH-1:0] expected_value(input logic [3:0] addr);
    case (addr)
      4'd1:    return WIDTH'(16'h000A);
      4'd2:    return WIDTH'(16'h0005);
      4'd3:    return WIDTH'(16'h000F);
      4'd4:    return WIDTH'(16'h0005);
      4'd6:    return WIDTH'(16'h000F);
      4'd7:    return WIDTH'(16'h000F);
      4'd8:    return WIDTH'(16'hFFF5);
      4'd9:    return WIDTH'(16'h0014);
      4'd10:   return WIDTH'(16'h0005);
      4'd11:   return WIDTH'(16'h0005);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    ffa_d    = ffa_q;
    ffd_d    = ffd_q;
    mismatch = (rd_data != expected_value(idx_q));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETUP;
          idx_d   = '0;
          err_d   = '0;
          ffa_d   = '0;
          ffd_d   = '0;
        end
      end
      SETUP: state_d = CHECK;
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (err_q == 5'd0) begin
            ffa_d = idx_q;
            ffd_d = rd_data;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; rst clears it without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      ffa_q   <= '0;
      ffd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      ffd_q   <= ffd_d;
    end
  end

  assign rd_addr         = idx_q;
  assign busy            = (state_q == SETUP) || (state_q == CHECK);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == 5'd0);
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_data = ffd_q;

endmodule
